multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder. A Moore-style FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB steps and drives datapath enables, mux selects and ALUOp per step. It waits on a memory-ready handshake and traps illegal opcodes and memory timeouts into a FAULT state. Sits between the instruction register and the shared multi-cycle datapath (PC, IR, register file, ALU, unified memory).

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/ctrl_mem_timer.sv | 37 +++
 rtl/multicycle_control_unit.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and datapath select codes.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_ALU_WB_R = 4'd8,
        S_EXEC_I   = 4'd9,
        S_ALU_WB_I = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_FAULT    = 4'd13
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_SLT   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    // Where a completing instruction goes next: keep running or park in IDLE.
    function automatic state_e return_state(input logic run);
        return run ? S_FETCH : S_IDLE;
    endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Counts consecutive memory-wait cycles; expired_o is high on the wait cycle that reaches TIMEOUT.
// TIMEOUT = 0 disables expiry entirely.
module ctrl_mem_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && en_i && !clear_i &&
                       ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB for the shared multi-cycle datapath; waits on mem_ready
// and traps illegal opcodes / memory timeouts into FAULT. CTRL_PERF_EN adds retired/cycle counters.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_src,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal,
    output logic                timeout,
    output logic [3:0]          state
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]         retired_cnt,
    output logic [31:0]         cycle_cnt
`endif
);

    state_e state_q;
    logic   illegal_q, timeout_q;
    logic   is_sw_q, is_slti_q, is_bne_q;
    logic   in_wait, tmr_expired;

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    ctrl_mem_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!in_wait || mem_ready),
        .en_i      (in_wait && !mem_ready),
        .expired_o (tmr_expired)
    );

    // Opcode-derived flags are latched in DECODE so later outputs depend only on registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            is_sw_q   <= 1'b0;
            is_slti_q <= 1'b0;
            is_bne_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (en) state_q <= S_FETCH;
                S_FETCH: begin
                    if (tmr_expired) begin
                        state_q   <= S_FAULT;
                        timeout_q <= 1'b1;
                    end else if (mem_ready) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    is_sw_q   <= (opcode == OPCODE_W'(OP_SW));
                    is_slti_q <= (opcode == OPCODE_W'(OP_SLTI));
                    is_bne_q  <= (opcode == OPCODE_W'(OP_BNE));
                    case (opcode)
                        OPCODE_W'(OP_RTYPE):                    state_q <= S_EXEC_R;
                        OPCODE_W'(OP_LW),   OPCODE_W'(OP_SW):   state_q <= S_MEM_ADDR;
                        OPCODE_W'(OP_SLTI), OPCODE_W'(OP_ADDI): state_q <= S_EXEC_I;
                        OPCODE_W'(OP_BEQ),  OPCODE_W'(OP_BNE):  state_q <= S_BRANCH;
                        OPCODE_W'(OP_J):                        state_q <= S_JUMP;
                        default: begin
                            state_q   <= S_FAULT;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: state_q <= is_sw_q ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD, S_MEM_WR: begin
                    if (tmr_expired) begin
                        state_q   <= S_FAULT;
                        timeout_q <= 1'b1;
                    end else if (mem_ready) begin
                        state_q <= (state_q == S_MEM_RD) ? S_MEM_WB : return_state(en);
                    end
                end
                S_EXEC_R: state_q <= S_ALU_WB_R;
                S_EXEC_I: state_q <= S_ALU_WB_I;
                S_MEM_WB, S_ALU_WB_R, S_ALU_WB_I, S_BRANCH, S_JUMP: state_q <= return_state(en);
                default: state_q <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = PCSRC_ALU;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALUOP_W'(ALU_ADD);
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(ALU_FUNCT);
            end
            S_ALU_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = is_slti_q ? ALUOP_W'(ALU_SLT) : ALUOP_W'(ALU_ADD);
            end
            S_ALU_WB_I: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                branch_ne     = is_bne_q;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;

`ifdef CTRL_PERF_EN
    logic        retire;
    logic [31:0] retired_q, cycle_q;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEM_WB, S_ALU_WB_R, S_ALU_WB_I, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WR: retire = mem_ready && !tmr_expired;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 32'd0;
            cycle_q   <= 32'd0;
        end else begin
            if (retire) retired_q <= retired_q + 32'd1;
            if (state_q != S_IDLE && state_q != S_FAULT) cycle_q <= cycle_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised instruction-level bench for multicycle_control_unit against a per-instruction phase model.
module tb_multicycle_control_unit;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;

    logic pc_write, pc_write_cond, branch_ne, ir_write, i_or_d, mem_read, mem_write;
    logic reg_write, reg_dst, mem_to_reg, alu_src_a, illegal, timeout;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    logic z_pc_write, z_pc_write_cond, z_branch_ne, z_ir_write, z_i_or_d, z_mem_read, z_mem_write;
    logic z_reg_write, z_reg_dst, z_mem_to_reg, z_alu_src_a, z_illegal, z_timeout;
    logic [1:0] z_pc_src, z_alu_src_b;
    logic [2:0] z_alu_op;
    logic [3:0] z_state;

`ifdef CTRL_PERF_EN
    logic [31:0] retired_cnt, cycle_cnt, z_retired_cnt, z_cycle_cnt;
    logic [31:0] m_retired = 32'd0;
    logic [31:0] m_cycles  = 32'd0;
`endif

    ctrl_t obs, z_obs;
    assign obs   = {pc_write, pc_write_cond, branch_ne, pc_src, ir_write, i_or_d, mem_read, mem_write,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};
    assign z_obs = {z_pc_write, z_pc_write_cond, z_branch_ne, z_pc_src, z_ir_write, z_i_or_d, z_mem_read,
                    z_mem_write, z_reg_write, z_reg_dst, z_mem_to_reg, z_alu_src_a, z_alu_src_b, z_alu_op};

    multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .timeout(timeout), .state(state)
`ifdef CTRL_PERF_EN
        , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
    );

    multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(0)) u_dut_nto (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(z_pc_write), .pc_write_cond(z_pc_write_cond), .branch_ne(z_branch_ne), .pc_src(z_pc_src),
        .ir_write(z_ir_write), .i_or_d(z_i_or_d), .mem_read(z_mem_read), .mem_write(z_mem_write),
        .reg_write(z_reg_write), .reg_dst(z_reg_dst), .mem_to_reg(z_mem_to_reg), .alu_src_a(z_alu_src_a),
        .alu_src_b(z_alu_src_b), .alu_op(z_alu_op), .illegal(z_illegal), .timeout(z_timeout), .state(z_state)
`ifdef CTRL_PERF_EN
        , .retired_cnt(z_retired_cnt), .cycle_cnt(z_cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic m_idle   = 1'b1;
    logic [5:0] legal_ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b001010,
                                  6'b001000, 6'b000100, 6'b000101, 6'b000010};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Sequence of steps each instruction class walks through; S_IDLE marks the end.
    function automatic state_e phase_at(input logic [5:0] op, input int i);
        state_e r [5];
        r = '{S_FETCH, S_DECODE, S_IDLE, S_IDLE, S_IDLE};
        case (op)
            6'b000000: begin r[2] = S_EXEC_R;   r[3] = S_ALU_WB_R; end
            6'b100011: begin r[2] = S_MEM_ADDR; r[3] = S_MEM_RD; r[4] = S_MEM_WB; end
            6'b101011: begin r[2] = S_MEM_ADDR; r[3] = S_MEM_WR; end
            6'b001010, 6'b001000: begin r[2] = S_EXEC_I; r[3] = S_ALU_WB_I; end
            6'b000100, 6'b000101: r[2] = S_BRANCH;
            6'b000010: r[2] = S_JUMP;
            default: ;
        endcase
        return r[i];
    endfunction

    function automatic ctrl_t exp_ctrl(input state_e p, input logic [5:0] op, input logic mr);
        ctrl_t c;
        c = '0;
        case (p)
            S_FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEM_RD:   begin c.mem_read = 1; c.i_or_d = 1; end
            S_MEM_WB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_MEM_WR:   begin c.mem_write = 1; c.i_or_d = 1; end
            S_EXEC_R:   begin c.alu_src_a = 1; c.alu_op = 3'b010; end
            S_ALU_WB_R: begin c.reg_write = 1; c.reg_dst = 1; end
            S_EXEC_I:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = (op == 6'b001010) ? 3'b111 : 3'b000; end
            S_ALU_WB_I: c.reg_write = 1;
            S_BRANCH:   begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1; c.pc_src = 2'b01;
                              c.branch_ne = (op == 6'b000101); end
            S_JUMP:     begin c.pc_write = 1; c.pc_src = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    // One clock: drive at posedge+1, compare both DUTs at the falling edge.
    task automatic cyc(input state_e p, input logic [5:0] op, input logic mr, input logic en_v,
                       input logic [5:0] opv);
        ctrl_t e;
        mem_ready = mr;
        en        = en_v;
        opcode    = opv;
        e = exp_ctrl(p, op, mr);
        @(negedge clk);
        check_eq("state", state, p);
        check_eq("ctrl", obs, e);
        check_eq("illegal", illegal, 1'b0);
        check_eq("timeout", timeout, 1'b0);
        check_eq("state_nto", z_state, p);
        check_eq("ctrl_nto", z_obs, e);
`ifdef CTRL_PERF_EN
        check_eq("retired_cnt", retired_cnt, m_retired);
        check_eq("cycle_cnt", cycle_cnt, m_cycles);
        if (p != S_IDLE && p != S_FAULT) m_cycles++;
        if (p inside {S_MEM_WB, S_ALU_WB_R, S_ALU_WB_I, S_BRANCH, S_JUMP} || (p == S_MEM_WR && mr))
            m_retired++;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_idle = 1'b1;
`ifdef CTRL_PERF_EN
        m_retired = 32'd0;
        m_cycles  = 32'd0;
`endif
    endtask

    task automatic run_instr(input logic [5:0] op, input logic en_end, input int lo_f, input int lo_m);
        state_e p;
        logic   last, wt;
        int     n_lo;
        if (m_idle) begin
            repeat ($urandom_range(0, 2)) cyc(S_IDLE, op, 1'($urandom), 1'b0, 6'($urandom));
            cyc(S_IDLE, op, 1'($urandom), 1'b1, 6'($urandom));
            m_idle = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            p = phase_at(op, i);
            if (p == S_IDLE) break;
            last = (i == 4) ? 1'b1 : (phase_at(op, i + 1) == S_IDLE);
            wt   = (p == S_FETCH) || (p == S_MEM_RD) || (p == S_MEM_WR);
            n_lo = (p == S_FETCH) ? lo_f : (wt ? lo_m : 0);
            for (int k = 0; k < n_lo; k++)
                cyc(p, op, 1'b0, last ? en_end : 1'($urandom), (p == S_FETCH) ? 6'($urandom) : op);
            cyc(p, op, wt ? 1'b1 : 1'($urandom), last ? en_end : 1'($urandom),
                (p == S_FETCH) ? 6'($urandom) : op);
        end
        if (!en_end) m_idle = 1'b1;
    endtask

    task automatic fault_hold(input string tag, input logic exp_ill, input logic exp_to, input int n);
        for (int k = 0; k < n; k++) begin
            en = 1'b1; mem_ready = 1'($urandom); opcode = 6'($urandom);
            @(negedge clk);
            check_eq({tag, "_state"}, state, S_FAULT);
            check_eq({tag, "_ctrl"}, obs, 18'd0);
            check_eq({tag, "_illegal"}, illegal, exp_ill);
            check_eq({tag, "_timeout"}, timeout, exp_to);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [5:0] op;
        #1 rst = 1'b1;
        #1;
        check_eq("reset_state", state, S_IDLE);
        check_eq("reset_ctrl", obs, 18'd0);
        check_eq("reset_illegal", illegal, 1'b0);
        check_eq("reset_timeout", timeout, 1'b0);
        do_reset();

        repeat (3) cyc(S_IDLE, 6'd0, 1'($urandom), 1'b0, 6'($urandom));
        run_instr(6'b000000, 1'b1, 0, 0);
        run_instr(6'b000000, 1'b1, 0, 0);
        run_instr(6'b100011, 1'b1, 0, 3);
        run_instr(6'b000101, 1'b1, 0, 0);
        run_instr(6'b000100, 1'b1, 1, 0);
        run_instr(6'b001010, 1'b1, 0, 0);
        run_instr(6'b001000, 1'b1, 2, 0);
        run_instr(6'b000010, 1'b1, 0, 0);
        run_instr(6'b100011, 1'b1, 15, 15);
        run_instr(6'b101011, 1'b0, 0, 2);
        cyc(S_IDLE, 6'd0, 1'b1, 1'b0, 6'd0);

        repeat (150) begin
            op = legal_ops[$urandom_range(0, 7)];
            run_instr(op, $urandom_range(0, 7) != 0, $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4));
        end

        // Illegal opcodes trap and hold until reset.
        do_reset();
        run_instr(6'b111111, 1'b1, 0, 0);
        fault_hold("illegal", 1'b1, 1'b0, 10);
        check_eq("illegal_nto", z_illegal, 1'b1);
        repeat (2) begin
            do_reset();
            do op = 6'($urandom); while (is_legal(op));
            run_instr(op, 1'b1, $urandom_range(0, 2), 0);
            fault_hold("illegal_rnd", 1'b1, 1'b0, 3);
        end

        // Fetch wait: 16 cycles then FAULT; the no-timeout instance keeps waiting.
        do_reset();
        cyc(S_IDLE, 6'd0, 1'b0, 1'b1, 6'd0);
        repeat (16) cyc(S_FETCH, 6'd0, 1'b0, 1'b1, 6'($urandom));
        for (int k = 0; k < 30; k++) begin
            mem_ready = 1'b0; en = 1'b1;
            @(negedge clk);
            check_eq("to_state", state, S_FAULT);
            check_eq("to_flag", timeout, 1'b1);
            check_eq("to_ctrl", obs, 18'd0);
            check_eq("nto_state", z_state, S_FETCH);
            check_eq("nto_flag", z_timeout, 1'b0);
            @(posedge clk);
            #1;
        end

        // Memory-read wait of 16 cycles also faults.
        do_reset();
        cyc(S_IDLE, 6'd0, 1'b0, 1'b1, 6'd0);
        cyc(S_FETCH, 6'b100011, 1'b1, 1'b1, 6'd0);
        cyc(S_DECODE, 6'b100011, 1'b0, 1'b1, 6'b100011);
        cyc(S_MEM_ADDR, 6'b100011, 1'b0, 1'b1, 6'b100011);
        repeat (16) cyc(S_MEM_RD, 6'b100011, 1'b0, 1'b1, 6'b100011);
        @(negedge clk);
        check_eq("rd_to_state", state, S_FAULT);
        check_eq("rd_to_flag", timeout, 1'b1);
        @(posedge clk);
        #1;

        // Async reset during a store write drops mem_write without a clock edge.
        do_reset();
        cyc(S_IDLE, 6'd0, 1'b0, 1'b1, 6'd0);
        cyc(S_FETCH, 6'b101011, 1'b1, 1'b1, 6'd0);
        cyc(S_DECODE, 6'b101011, 1'b0, 1'b1, 6'b101011);
        cyc(S_MEM_ADDR, 6'b101011, 1'b0, 1'b1, 6'b101011);
        mem_ready = 1'b0; en = 1'b1;
        @(negedge clk);
        check_eq("wr_mem_write", mem_write, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_state", state, S_IDLE);
        @(posedge clk);
        #1 rst = 1'b0;
        m_idle = 1'b1;
`ifdef CTRL_PERF_EN
        m_retired = 32'd0;
        m_cycles  = 32'd0;
`endif
        run_instr(6'b101011, 1'b0, 0, 1);
        cyc(S_IDLE, 6'd0, 1'b1, 1'b0, 6'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
